// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch controller and its digit cells.
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Prescaler register width; a single bit is kept even when PRESCALE is 1 or 2.
    function automatic int prescWidth(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch chain; carry-out flags the digit sitting at 9.
module bcd_digit
    import bcd_stopwatch_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output bcd_t q_o,
    output logic co_o
);

    bcd_t digit_q;

    // The >= compare keeps the digit inside 0..9 even from an unexpected state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            digit_q <= '0;
        end else if (inc_i) begin
            digit_q <= (digit_q >= BCD_MAX) ? bcd_t'(0) : digit_q + bcd_t'(1);
        end
    end

    assign q_o  = digit_q;
    assign co_o = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller for a cascaded BCD counter with prescaled count ticks.
// Define BCD_STOPWATCH_LAP_EN to build the lap-freeze register for the display output.
module bcd_stopwatch_ctrl
    import bcd_stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                clear_i,
    input  logic                lap_i,
    output logic [4*DIGITS-1:0] count_o,
    output logic [4*DIGITS-1:0] display_o,
    output logic                running_o,
    output logic                tc_o,
    output logic                overflow_o
);

    localparam int            PW         = prescWidth(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_e              state_q;
    logic [PW-1:0]       presc_q;
    logic                running_q;
    logic                tc_q;
    logic                overflow_q;
    logic [4*DIGITS-1:0] count;
    logic [DIGITS-1:0]   digitInc;
    logic [DIGITS-1:0]   digitCarry;
    logic                carryAll;
    logic                advance;
    logic                tick;
    logic                wrap;

    // A stop or clear in the same cycle freezes the prescaler and swallows any pending tick.
    assign advance = (state_q == RUN) && !clear_i && !stop_i;
    assign tick    = advance && (presc_q == PRESC_LAST);
    assign wrap    = tick && (&digitCarry);

    always_comb begin
        digitInc = '0;
        carryAll = tick;
        for (int i = 0; i < DIGITS; i++) begin
            digitInc[i] = carryAll;
            carryAll    = carryAll & digitCarry[i];
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : gDigit
        bcd_digit uDigit (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (digitInc[gi]),
            .q_o   (count[4*gi +: 4]),
            .co_o  (digitCarry[gi])
        );
    end

    // Commands resolve as clear > stop > start, so a lower command is dropped even when the higher one is a no-op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            tc_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tc_q <= wrap;
            if (wrap) begin
                overflow_q <= 1'b1;
            end
            if (advance) begin
                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            end
            if (clear_i) begin
                state_q    <= IDLE;
                running_q  <= 1'b0;
                presc_q    <= '0;
                overflow_q <= 1'b0;
            end else if (stop_i) begin
                if (state_q == RUN) begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
            end else if (start_i) begin
                if (state_q == IDLE) begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                    presc_q   <= '0;
                end else if (state_q == PAUSE) begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic                lapFrozen_q;
    logic [4*DIGITS-1:0] lapValue_q;

    // Capture takes the pre-edge count so the frozen value matches what was on screen.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            lapFrozen_q <= 1'b0;
            lapValue_q  <= '0;
        end else if (lap_i && !stop_i && !start_i) begin
            if (lapFrozen_q) begin
                lapFrozen_q <= 1'b0;
            end else if (state_q == RUN) begin
                lapFrozen_q <= 1'b1;
                lapValue_q  <= count;
            end
        end
    end

    assign display_o = lapFrozen_q ? lapValue_q : count;
`else
    logic unusedLap;
    assign unusedLap = lap_i;
    assign display_o = count;
`endif

    assign count_o    = count;
    assign running_o  = running_q;
    assign tc_o       = tc_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: a fast (PRESCALE=1) and a slow (PRESCALE=4) two-digit instance share commands.
module tb_bcd_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic       lap;
    logic [7:0] countF, displayF, countS, displayS;
    logic       runningF, tcF, overflowF;
    logic       runningS, tcS, overflowS;
    int         vectors     = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(1)) dutFast (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .clear_i    (clear),
        .lap_i      (lap),
        .count_o    (countF),
        .display_o  (displayF),
        .running_o  (runningF),
        .tc_o       (tcF),
        .overflow_o (overflowF)
    );

    bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(4)) dutSlow (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .clear_i    (clear),
        .lap_i      (lap),
        .count_o    (countS),
        .display_o  (displayS),
        .running_o  (runningS),
        .tc_o       (tcS),
        .overflow_o (overflowS)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Commands are held for one edge; outputs are then stable for sampling.
    task automatic applyStimulus(input logic doStart, input logic doStop, input logic doClear, input logic doLap);
        start = doStart;
        stop  = doStop;
        clear = doClear;
        lap   = doLap;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstCount", countF, 8'h00);
        checkOutput("rstDisplay", displayF, 8'h00);
        checkOutput("rstRunning", runningF, 1'b0);
        checkOutput("rstTc", tcF, 1'b0);
        checkOutput("rstOverflow", overflowF, 1'b0);
        rst = 1'b0;

        // cascade and wrap on the fast instance
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("startRunning", runningF, 1'b1);
        checkOutput("startNoInc", countF, 8'h00);
        waitCycles(9);
        checkOutput("count09", countF, 8'h09);
        waitCycles(1);
        checkOutput("carry10", countF, 8'h10);
        checkOutput("slowAt10", countS, 8'h02);
        waitCycles(89);
        checkOutput("count99", countF, 8'h99);
        checkOutput("tcBeforeWrap", tcF, 1'b0);
        waitCycles(1);
        checkOutput("wrap00", countF, 8'h00);
        checkOutput("wrapTc", tcF, 1'b1);
        checkOutput("wrapOverflow", overflowF, 1'b1);
        checkOutput("slowAt100", countS, 8'h25);
        checkOutput("slowDisplay", displayS, 8'h25);
        checkOutput("slowNoOverflow", overflowS, 1'b0);
        checkOutput("slowNoTc", tcS, 1'b0);
        waitCycles(1);
        checkOutput("after01", countF, 8'h01);
        checkOutput("tcOneCycle", tcF, 1'b0);
        checkOutput("overflowSticky", overflowF, 1'b1);

        // stop freezes the count on its own edge
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stopCount", countF, 8'h01);
        checkOutput("stopRunning", runningF, 1'b0);
        checkOutput("stopSlowCount", countS, 8'h25);
        checkOutput("stopSlowRunning", runningS, 1'b0);
        waitCycles(5);
        checkOutput("pauseHold", countF, 8'h01);
        checkOutput("pauseOverflow", overflowF, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clearCount", countF, 8'h00);
        checkOutput("clearOverflow", overflowF, 1'b0);
        checkOutput("clearSlowCount", countS, 8'h00);

        // pause keeps the slow prescaler at 2, so resume increments after two edges
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("slowPausedCount", countS, 8'h00);
        checkOutput("fastPausedCount", countF, 8'h02);
        waitCycles(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resumeRunning", runningS, 1'b1);
        checkOutput("resumeEdge", countS, 8'h00);
        waitCycles(1);
        checkOutput("resumePlus1", countS, 8'h00);
        waitCycles(1);
        checkOutput("resumePlus2", countS, 8'h01);
        checkOutput("fastResume", countF, 8'h04);

        // command priority
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("prioAllRunning", runningF, 1'b0);
        checkOutput("prioAllCount", countF, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("prioPauseCount", countF, 8'h01);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("prioStopStart", runningF, 1'b0);
        waitCycles(3);
        checkOutput("prioStillPaused", countF, 8'h01);

        // lap freeze
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("lapPre", countF, 8'h05);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lapCount", countF, 8'h06);
`ifdef BCD_STOPWATCH_LAP_EN
        checkOutput("lapCapture", displayF, 8'h05);
`else
        checkOutput("lapIgnored", displayF, 8'h06);
`endif
        waitCycles(6);
        checkOutput("lapLive", countF, 8'h12);
`ifdef BCD_STOPWATCH_LAP_EN
        checkOutput("lapHeld", displayF, 8'h05);
`else
        checkOutput("lapLiveDisplay", displayF, 8'h12);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lapReleaseCount", countF, 8'h13);
        checkOutput("lapReleaseDisplay", displayF, 8'h13);

        // reset mid-run overrides a simultaneous start
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("preResetCount", countF, 8'h10);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("midRstCount", countF, 8'h00);
        checkOutput("midRstRunning", runningF, 1'b0);
        checkOutput("midRstOverflow", overflowF, 1'b0);
        checkOutput("midRstDisplay", displayF, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Run/pause/clear controller for a cascaded multi-digit decimal (BCD) counter. The block prescales the system clock into count ticks and sequences the digit chain through a start/stop/clear state machine. It flags terminal count and sticky overflow, and optionally freezes a lap value for display. It sits between front-panel command pulses and the seven-segment display driver.

## Interface
- `DIGITS`, default 4: number of BCD digits in the chain, 1..8.
- `PRESCALE`, default 10: clock cycles per count tick, ≥1. The prescaler width is clog2(PRESCALE), minimum 1.
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle command; begin or resume counting.
- `stop` in 1: single-cycle command; pause counting.
- `clear` in 1: single-cycle command; zero the count and return to IDLE.
- `lap` in 1: single-cycle command; toggle lap freeze (only with `BCD_STOPWATCH_LAP_EN`).
- `count` out 4*DIGITS: live packed BCD count; digit 0 (least significant) in bits [3:0].
- `display` out 4*DIGITS: value for the display driver, either the live count or the frozen lap value.
- `running` out 1: high in RUN.
- `tc` out 1: one-cycle pulse on the edge where the count wraps from all-9s to all-0s.
- `overflow` out 1: sticky; set with `tc`.

## Operation
- **States:** IDLE, RUN, PAUSE. All outputs are registered.
- **Reset (`rst`=1):** state=IDLE, count=0, display=0, prescaler=0, running=0, tc=0, overflow=0, lap freeze off. Reset overrides every command in any state.
- **Command priority** when commands arrive in the same cycle: clear > stop > start > lap.
- **IDLE:**
  - start → RUN with prescaler=0.
  - stop is ignored.
  - clear keeps the count at 0.
- **RUN:**
  - stop → PAUSE.
  - clear → IDLE; count=0, prescaler=0, overflow=0, freeze off.
  - start is ignored.
- **PAUSE:**
  - start → RUN. The prescaler resumes from its held value and is not reset.
  - clear → IDLE, same effects as clear in RUN.
  - stop is ignored.
- **Prescaler:**
  - Counts 0..PRESCALE-1 only in RUN, and wraps to 0.
  - tick = RUN and prescaler==PRESCALE-1.
  - With PRESCALE=1, tick fires every RUN cycle.
- **Digit cascade:**
  - Digit 0 increments on tick.
  - Digit i increments on tick when digits 0..i-1 are all 9.
  - A digit at 9 that increments becomes 0. Digits never take values A–F.
- **Wrap:** a tick while all digits are 9 sets all digits to 0, pulses tc, and sets overflow. overflow stays set until clear or rst.
- **Stop with a pending tick:** the stop cycle has priority. No increment occurs on that edge.

## Timing
- **start latency:** start sampled at edge N gives running=1 after edge N. The first increment is at edge N+PRESCALE.
- **stop latency:** stop sampled at edge M gives running=0 after M. The count is frozen at its pre-M value.
- **clear latency:** count=0 after the sampling edge.
- **Outputs:** tc is high for exactly the cycle following the wrap edge. count and display update on the same edge.
- **Increment rate:** at most one increment per PRESCALE cycles in continuous RUN.

## Configuration
- **With `BCD_STOPWATCH_LAP_EN` defined:**
  - lap in RUN with freeze off sets freeze and captures the count as of the sampling edge (the value before that edge's increment).
  - lap while frozen releases the freeze.
  - lap in IDLE or PAUSE releases the freeze if it is set, otherwise it is ignored.
  - display = frozen ? lap register : count.
  - clear and rst release the freeze.
- **Without the macro:** the lap input is unused, no lap register is built, and display = count.

## Structure
- **Shared package `bcd_stopwatch_pkg`:**
  - State enum (IDLE/RUN/PAUSE).
  - BCD digit type (4 bits).
  - `BCD_MAX` = 4'd9.
  - Helper function for prescaler width.
- **Sub-module `bcd_digit`:**
  - Ports: clk, rst, clr, inc (carry-in); q[3:0] and carry-out (q==9).
  - Instantiated DIGITS times via generate, chained through carry-out AND tick.

## Test plan
- **Reset mid-run:** DIGITS=2, PRESCALE=2, start, run 10 cycles, assert rst → count=00, running=0, overflow=0 on the next cycle.
- **Cascade carry:** PRESCALE=1, start, run 10 cycles → count goes 09→10 at the 10th edge; digit values never exceed 9.
- **Wrap:** DIGITS=2, PRESCALE=1, run 100 cycles → count 99→00, tc high for one cycle, overflow stays 1 until clear.
- **Pause holds prescaler:** PRESCALE=4, start, stop after 2 cycles, wait 20, start → the next increment comes 2 cycles after resume, not 4.
- **Priority:** start+stop+clear in the same RUN cycle → IDLE, count=0; stop+start in PAUSE → remains PAUSE.
- **Lap (macro on):** PRESCALE=1, lap at count=05 → display holds 05 while count advances to 12; a second lap shows the live count.
